// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - square-wave note decoder with segment events
//
// Purpose: measures edge-to-edge intervals on a square-wave audio line and
// classifies each half-period as one of the melody notes C5..G5, unknown or
// silence. One event is emitted per completed segment, giving the note code
// and the duration in ticks.
//
// Ports:
//   iCLK       clock
//   iRST_N     synchronous reset, active-low
//   iSOUND     asynchronous square-wave input
//   oNOTE      current locked class: 0 rest, 1..5 C5..G5, 7 unknown
//   oLOCK      1 while oNOTE is non-zero
//   oEV_VALID  single-cycle pulse when the previous segment has ended
//   oEV_NOTE   class of the ended segment (held)
//   oEV_DUR    duration of the ended segment in ticks (held)
module tone_decoder #(
  parameter int TICK_CYC = 12_500_000,
  parameter int SIL_CYC  = 200_000,
  parameter int TOL      = 512,
  parameter int LOCK_N   = 3,
  parameter int NOM_C5   = 47_774,
  parameter int NOM_D5   = 42_568,
  parameter int NOM_E5   = 37_919,
  parameter int NOM_F5   = 35_791,
  parameter int NOM_G5   = 31_888
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSOUND,
  output logic [2:0] oNOTE,
  output logic       oLOCK,
  output logic       oEV_VALID,
  output logic [2:0] oEV_NOTE,
  output logic [8:0] oEV_DUR
);

  localparam int SUB_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int LCK_W = $clog2(LOCK_N + 1);
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(TICK_CYC - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(TICK_CYC / 2);
  localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_N);
  localparam logic [20:0]      SIL_LIM  = 21'(SIL_CYC);
  localparam logic [20:0]      CNT_MAX  = 21'h1F_FFFF;

  typedef enum logic [1:0] {REST, TONE, UNK} tState;

  tState            state, nextState;
  logic             sync1, sync2, sync3;
  logic [20:0]      intCnt, nextIntCnt;
  logic             haveEdge, nextHaveEdge;
  logic [2:0]       prevClass, nextPrevClass;
  logic [LCK_W-1:0] lockCnt, nextLockCnt;
  logic [SUB_W-1:0] subCnt, nextSubCnt;
  logic [8:0]       tickCnt, nextTickCnt;
  logic             firstFlag, nextFirstFlag;
  logic [2:0]       nextNote;
  logic             nextEvValid;
  logic [2:0]       nextEvNote;
  logic [8:0]       nextEvDur;

  logic             edgeDet;
  logic [2:0]       hClass;
  logic [LCK_W-1:0] lockNew;
  logic             segChange;
  logic [2:0]       segNote;
  logic [9:0]       durSum;
  logic [8:0]       durNow;

  function automatic logic [2:0] classify(input logic [20:0] h);
    int hv;
    hv = int'(h);
    classify = 3'd7;
    if ((hv - NOM_C5 <= TOL) && (NOM_C5 - hv <= TOL)) classify = 3'd1;
    if ((hv - NOM_D5 <= TOL) && (NOM_D5 - hv <= TOL)) classify = 3'd2;
    if ((hv - NOM_E5 <= TOL) && (NOM_E5 - hv <= TOL)) classify = 3'd3;
    if ((hv - NOM_F5 <= TOL) && (NOM_F5 - hv <= TOL)) classify = 3'd4;
    if ((hv - NOM_G5 <= TOL) && (NOM_G5 - hv <= TOL)) classify = 3'd5;
  endfunction

  assign edgeDet = sync2 ^ sync3;
  assign hClass  = classify(intCnt);
  assign oLOCK   = (state != REST);

  // Rounded duration of the running segment: half a tick or more rounds up.
  assign durSum = {1'b0, tickCnt} + 10'(subCnt >= SUB_HALF);
  assign durNow = durSum[9] ? 9'd511 : durSum[8:0];

  always_comb begin
    nextIntCnt    = (intCnt == CNT_MAX) ? intCnt : intCnt + 21'd1;
    nextHaveEdge  = haveEdge;
    nextPrevClass = prevClass;
    nextLockCnt   = lockCnt;
    nextFirstFlag = firstFlag;
    nextNote      = oNOTE;
    nextState     = state;
    nextEvValid   = 1'b0;
    nextEvNote    = oEV_NOTE;
    nextEvDur     = oEV_DUR;
    lockNew       = lockCnt;
    segChange     = 1'b0;
    segNote       = oNOTE;

    if (edgeDet) begin
      // An edge always wins over a coincident silence threshold.
      nextIntCnt   = 21'd1;
      nextHaveEdge = 1'b1;
      if (haveEdge) begin
        // lockCnt == 0 marks an empty history, so the first H never matches.
        if ((lockCnt != '0) && (hClass == prevClass))
          lockNew = (lockCnt == LCK_MAX) ? LCK_MAX : lockCnt + LCK_W'(1);
        else
          lockNew = LCK_W'(1);
        nextPrevClass = hClass;
        nextLockCnt   = lockNew;
        if ((lockNew == LCK_MAX) && (hClass != oNOTE)) begin
          segChange = 1'b1;
          segNote   = hClass;
        end
      end
    end else if ((intCnt == SIL_LIM) && (oNOTE != 3'd0)) begin
      segChange     = 1'b1;
      segNote       = 3'd0;
      nextHaveEdge  = 1'b0;
      nextLockCnt   = '0;
      nextPrevClass = 3'd0;
    end

    if (subCnt == SUB_MAX) begin
      nextSubCnt  = '0;
      nextTickCnt = (tickCnt == 9'd511) ? tickCnt : tickCnt + 9'd1;
    end else begin
      nextSubCnt  = subCnt + SUB_W'(1);
      nextTickCnt = tickCnt;
    end

    if (segChange) begin
      nextNote    = segNote;
      nextSubCnt  = '0;
      nextTickCnt = 9'd0;
      if (segNote == 3'd0)      nextState = REST;
      else if (segNote == 3'd7) nextState = UNK;
      else                      nextState = TONE;
      // The segment before the first lock after reset is not reported.
      if (!firstFlag) begin
        nextEvValid = 1'b1;
        nextEvNote  = oNOTE;
        nextEvDur   = durNow;
      end
      nextFirstFlag = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      intCnt    <= 21'd0;
      haveEdge  <= 1'b0;
      prevClass <= 3'd0;
      lockCnt   <= '0;
      subCnt    <= '0;
      tickCnt   <= 9'd0;
      firstFlag <= 1'b1;
      state     <= REST;
      oNOTE     <= 3'd0;
      oEV_VALID <= 1'b0;
      oEV_NOTE  <= 3'd0;
      oEV_DUR   <= 9'd0;
    end else begin
      sync1     <= iSOUND;
      sync2     <= sync1;
      sync3     <= sync2;
      intCnt    <= nextIntCnt;
      haveEdge  <= nextHaveEdge;
      prevClass <= nextPrevClass;
      lockCnt   <= nextLockCnt;
      subCnt    <= nextSubCnt;
      tickCnt   <= nextTickCnt;
      firstFlag <= nextFirstFlag;
      state     <= nextState;
      oNOTE     <= nextNote;
      oEV_VALID <= nextEvValid;
      oEV_NOTE  <= nextEvNote;
      oEV_DUR   <= nextEvDur;
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - directed self-checking bench for tone_decoder
module tb_tone_decoder;

  localparam int TICK = 1000;
  localparam int SIL  = 2000;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iSOUND = 1'b0;
  logic [2:0] oNOTE;
  logic       oLOCK;
  logic       oEV_VALID;
  logic [2:0] oEV_NOTE;
  logic [8:0] oEV_DUR;

  int errors = 0;
  int checks = 0;
  int evCount = 0;
  int evBase = 0;

  tone_decoder #(
    .TICK_CYC(TICK), .SIL_CYC(SIL), .TOL(10), .LOCK_N(3),
    .NOM_C5(480), .NOM_D5(420), .NOM_E5(380), .NOM_F5(350), .NOM_G5(320)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSOUND(iSOUND),
    .oNOTE(oNOTE), .oLOCK(oLOCK), .oEV_VALID(oEV_VALID),
    .oEV_NOTE(oEV_NOTE), .oEV_DUR(oEV_DUR)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) if (oEV_VALID === 1'b1) evCount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic toggles(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      iSOUND = ~iSOUND;
      if (i < n - 1) tick(d);
    end
  endtask

  task automatic doReset();
    iSOUND = 1'b0;
    iRST_N = 1'b0;
    tick(3);
    iRST_N = 1'b1;
    tick(2);
    evBase = evCount;
  endtask

  initial begin
    // Reset held with the input toggling
    @(negedge iCLK);
    for (int i = 0; i < 5; i++) begin
      iSOUND = ~iSOUND;
      tick(1);
    end
    check("rst_note", 32'(oNOTE), 0);
    check("rst_lock", 32'(oLOCK), 0);
    check("rst_valid", 32'(oEV_VALID), 0);
    check("rst_evnote", 32'(oEV_NOTE), 0);
    check("rst_evdur", 32'(oEV_DUR), 0);
    iSOUND = 1'b0;
    iRST_N = 1'b1;
    tick(1000);
    check("rst_noev", 32'(evCount), 0);
    check("rst_note_idle", 32'(oNOTE), 0);

    // G5 lock, then silence
    doReset();
    toggles(4, 320);
    tick(2);
    check("g5_prelock", 32'(oNOTE), 0);
    tick(1);
    check("g5_lock_note", 32'(oNOTE), 5);
    check("g5_lock_lock", 32'(oLOCK), 1);
    check("g5_first_noev", 32'(oEV_VALID), 0);
    tick(317);
    toggles(16, 320);
    tick(SIL + 2);
    check("g5_presil_valid", 32'(oEV_VALID), 0);
    check("g5_presil_note", 32'(oNOTE), 5);
    tick(1);
    check("g5_sil_valid", 32'(oEV_VALID), 1);
    check("g5_sil_evnote", 32'(oEV_NOTE), 5);
    check("g5_sil_evdur", 32'(oEV_DUR), 7);
    check("g5_sil_note", 32'(oNOTE), 0);
    check("g5_sil_lock", 32'(oLOCK), 0);
    tick(1);
    check("g5_pulse_end", 32'(oEV_VALID), 0);
    check("g5_evnote_held", 32'(oEV_NOTE), 5);

    // Direct G5 -> E5 change
    doReset();
    toggles(11, 320);
    tick(380);
    toggles(3, 380);
    tick(2);
    check("chg_pre_valid", 32'(oEV_VALID), 0);
    check("chg_pre_note", 32'(oNOTE), 5);
    tick(1);
    check("chg_valid", 32'(oEV_VALID), 1);
    check("chg_evnote", 32'(oEV_NOTE), 5);
    check("chg_evdur", 32'(oEV_DUR), 3);
    check("chg_note", 32'(oNOTE), 3);
    check("chg_evcount", 32'(evCount - evBase), 0);
    tick(1);
    check("chg_evdur_held", 32'(oEV_DUR), 3);

    // Tolerance boundary
    doReset();
    toggles(4, 330);
    tick(3);
    check("tol_in_note", 32'(oNOTE), 5);
    doReset();
    toggles(4, 331);
    tick(2);
    check("tol_out_pre", 32'(oNOTE), 0);
    tick(1);
    check("tol_out_note", 32'(oNOTE), 7);
    check("tol_out_lock", 32'(oLOCK), 1);
    check("tol_out_noev", 32'(oEV_VALID), 0);

    // Glitch rejection
    doReset();
    toggles(4, 320);
    tick(3);
    check("gl_lock", 32'(oNOTE), 5);
    tick(317);
    iSOUND = ~iSOUND;
    tick(100);
    iSOUND = ~iSOUND;
    tick(3);
    check("gl_after_short", 32'(oNOTE), 5);
    tick(317);
    iSOUND = ~iSOUND;
    for (int i = 0; i < 4; i++) begin
      tick(320);
      iSOUND = ~iSOUND;
    end
    tick(5);
    check("gl_note_kept", 32'(oNOTE), 5);
    check("gl_noev", 32'(evCount - evBase), 0);

    // Reset mid-tone
    doReset();
    toggles(6, 380);
    tick(10);
    check("mid_lock", 32'(oNOTE), 3);
    evBase = evCount;
    iRST_N = 1'b0;
    tick(1);
    check("mid_rst_note", 32'(oNOTE), 0);
    check("mid_rst_lock", 32'(oLOCK), 0);
    check("mid_rst_valid", 32'(oEV_VALID), 0);
    iRST_N = 1'b1;
    tick(5);
    check("mid_rst_noev", 32'(evCount - evBase), 0);
    toggles(4, 380);
    tick(2);
    check("mid_prelock", 32'(oNOTE), 0);
    tick(1);
    check("mid_relock", 32'(oNOTE), 3);
    check("mid_relock_noev", 32'(oEV_VALID), 0);
    tick(377);
    toggles(5, 380);
    tick(SIL + 2);
    check("mid_presil_valid", 32'(oEV_VALID), 0);
    tick(1);
    check("mid_sil_valid", 32'(oEV_VALID), 1);
    check("mid_sil_evnote", 32'(oEV_NOTE), 3);
    check("mid_sil_evdur", 32'(oEV_DUR), 4);
    check("mid_sil_note", 32'(oNOTE), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receiver-side counterpart of the melody player. Takes a square-wave audio line and measures the interval between edges.
- Classifies each interval as one of the five melody notes (C5..G5), as "unknown", or as silence.
- Emits one event per completed segment, carrying the note code and the duration in melody ticks (0.25 s at 50 MHz).
- Used for loopback self-check of the melody player.

Parameters:
- TICK_CYC, 12_500_000, iCLK cycles per duration tick.
- SIL_CYC, 200_000, cycles with no edge before the line is declared silent.
- TOL, 512, maximum |measured − nominal| half-period (cycles) for a note match.
- LOCK_N, 3, consecutive identical half-period classes required to change the current note.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  synchronous reset, active-low.
- iSOUND  in  1  asynchronous square-wave input.
- oNOTE  out  3  current locked class: 0 = rest, 1..5 = C5, D5, E5, F5, G5, 7 = unknown.
- oLOCK  out  1  1 while oNOTE is in 1..7.
- oEV_VALID  out  1  single-cycle pulse; the previous segment has ended.
- oEV_NOTE  out  3  class of the ended segment; valid with oEV_VALID, held afterwards.
- oEV_DUR  out  9  duration of the ended segment in ticks; valid with oEV_VALID, held afterwards.

Behaviour:
- Reset:
  - Reset is synchronous, active-low, and checked every iCLK edge.
  - All outputs go to 0. Synchronizer, interval counter, class history and duration counters are cleared.
  - State becomes REST with the "first" flag set.
  - Reset asserted mid-segment discards that segment; no event is produced.
- Input path:
  - 2-FF synchronizer, then a third flop for edge detect. Both edges count.
  - Edge detection lags iSOUND by 2-3 cycles.
- Interval counter (21 bits):
  - Increments every cycle and saturates at 2^21−1.
  - On an edge, the counter value is H (one half-period) and the counter then restarts at 1.
  - The first edge after REST or reset gives no H; it only starts the counter.
- Classification of H:
  - Nominal half-periods: C5 = 47_774, D5 = 42_568, E5 = 37_919, F5 = 35_791, G5 = 31_888.
  - Class = matching note code if |H − nominal| ≤ TOL, otherwise 7.
  - Windows do not overlap at TOL = 512.
- Lock counter:
  - Increments when the class equals the previous class, saturating at LOCK_N.
  - Resets to 1 when the class differs.
  - When it reaches LOCK_N and the class ≠ oNOTE, a segment change to that class occurs in the same cycle.
- Silence:
  - When the interval counter reaches SIL_CYC with no edge and oNOTE ≠ 0, a segment change to rest (0) occurs.
  - The lock history and the "have-edge" flag are cleared.
  - No LOCK_N qualification applies to silence.
- States:
  - REST (oNOTE = 0), TONE (oNOTE = 1..5), UNK (oNOTE = 7).
  - Transitions occur only on a segment change.
- Segment change at cycle t:
  - oNOTE and oLOCK update at t+1.
  - At t+1, unless the "first" flag is set: oEV_VALID = 1, oEV_NOTE = old class, oEV_DUR = old duration. The "first" flag then clears.
  - The duration counters restart at t+1.
- Duration:
  - A sub-counter counts 0..TICK_CYC−1; on wrap, a 9-bit tick count increments, saturating at 511.
  - At the change, reported duration = ticks + (sub ≥ TICK_CYC/2 ? 1 : 0), saturating at 511.
- Simultaneous events:
  - If an edge and the silence threshold fall in the same cycle, the edge wins and silence is not declared.
  - The minimum event spacing is LOCK_N half-periods, so no buffering is needed and no event is lost.

Test Plan:
- Reset: hold iRST_N = 0 for 5 cycles with iSOUND toggling -> all outputs 0, no oEV_VALID for 1000 cycles with iSOUND low.
- G5 then silence:
  - Stimulus: half-period 31_888 for 75_000_000 cycles, then low.
  - oNOTE = 5 at 4th edge + 1 cycle; no event at that lock (first flag).
  - Silence declared 200_000 cycles after the last edge -> oEV_VALID with NOTE = 5, DUR = 6, then oNOTE = 0.
- Direct note change:
  - Stimulus: 10 half-periods of 31_888, then 37_919.
  - Event with NOTE = 5 exactly when the 3rd 37_919 half-period ends (+1 cycle); oNOTE then becomes 3.
- Tolerance boundary:
  - Half-period 31_888 + 512 -> oNOTE = 5.
  - Half-period 31_888 + 513 -> oNOTE = 7 after 3 half-periods.
- Glitch rejection:
  - Stimulus: locked G5, then one half-period of 20_000, then G5 resumes.
  - Required: no oEV_VALID and oNOTE stays 5.
- Reset mid-tone:
  - Stimulus: iRST_N low 1 cycle during a locked E5 tone.
  - Outputs 0 with no event; after relock (oNOTE = 3, no event), silence yields an event with NOTE = 3 and the duration counted from the relock.
